// File: rtl/etapa_if.sv
// etapa_if: MIPS-style instruction fetch stage holding the PC and the IF/ID pipeline register.
// Ports:
//    clk, reset     - single clock, synchronous active-high reset
//    SEL_DIR        - next-PC select: 00 PC+4, 01 jump, 10 jr, 11 PC+4
//    resetIF        - flush IF/ID to a bubble
//    stall          - hold PC and IF/ID (beats resetIF and SEL_DIR)
//    jr_dir         - register value used as the jr target
//    instr_mem      - instruction memory read data for PC_IM
//    PC_IM          - current PC / instruction memory address
//    instr_ID, PC4_ID, valid_ID - IF/ID register contents
//    opcode, funct  - decoder fields sliced from instr_ID
// Optional: define ETAPA_IF_CONTADOR_EN to add cnt_instr (fetched instructions)
//    and cnt_flush (flushes) counters.
module etapa_if (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  SEL_DIR,
   input  logic        resetIF,
   input  logic        stall,
   input  logic [31:0] jr_dir,
   input  logic [31:0] instr_mem,
   output logic [31:0] PC_IM,
   output logic [31:0] instr_ID,
   output logic [31:0] PC4_ID,
   output logic        valid_ID,
   output logic [5:0]  opcode,
   output logic [5:0]  funct
`ifdef ETAPA_IF_CONTADOR_EN
   ,
   output logic [31:0] cnt_instr,
   output logic [15:0] cnt_flush
`endif
);
   logic [31:0] pc4;
   logic [31:0] pc_next;
   logic        load;
   logic        flush;
   assign pc4    = PC_IM + 32'd4;
   assign opcode = instr_ID[31:26];
   assign funct  = instr_ID[5:0];
   assign load   = !stall && !resetIF;
   assign flush  = !stall && resetIF;
   // Jump target comes from the instruction already in ID, not the one being fetched.
   always_comb
      pc_next = (SEL_DIR == 2'b01) ? {PC4_ID[31:28], instr_ID[25:0], 2'b00} :
                (SEL_DIR == 2'b10) ? {jr_dir[31:2], 2'b00} : pc4;
   always_ff @(posedge clk)
      if (reset)
         PC_IM <= 32'd0;
      else if (!stall)
         PC_IM <= pc_next;
   always_ff @(posedge clk)
      if (reset || flush) begin
         instr_ID <= 32'd0;
         PC4_ID   <= 32'd0;
         valid_ID <= 1'b0;
      end else if (load) begin
         instr_ID <= instr_mem;
         PC4_ID   <= pc4;
         valid_ID <= 1'b1;
      end
`ifdef ETAPA_IF_CONTADOR_EN
   always_ff @(posedge clk)
      if (reset) begin
         cnt_instr <= 32'd0;
         cnt_flush <= 16'd0;
      end else begin
         if (load)
            cnt_instr <= cnt_instr + 32'd1;
         if (flush)
            cnt_flush <= cnt_flush + 16'd1;
      end
`endif
endmodule
